mem_tag_remap: RTL and testbench
================================

# mem_tag_remap

Memory-side tag compressor between a cache's line-size memory bus and the external memory port. Read requests carry wide cache tags (MSHR id, bank id, UUID). Each read gets a small ID from a free list, and its original tag is parked in an on-chip table. When the matching response returns, the original tag is restored. This caps the number of outstanding reads at NUM_IDS and narrows the tag presented to the memory system.

## Interface
Parameters:
- ADDR_WIDTH, 26: line address width.
- DATA_SIZE, 64: line size in bytes. Data width is 8*DATA_SIZE.
- TAG_IN_WIDTH, 12: cache-side tag width.
- NUM_IDS, 8: maximum outstanding reads. Must be a power of two, at least 2.
- ID_WIDTH, log2(NUM_IDS): memory-side tag width. This is a derived localparam.

Ports:
- clk, in, 1: clock. All state changes on the rising edge.
- reset, in, 1: asynchronous, active-low reset.
- in_req_valid/in_req_ready, in/out, 1: request handshake from the cache.
- in_req_rw, in, 1: 1 = write, 0 = read.
- in_req_addr, in, ADDR_WIDTH: line address.
- in_req_byteen, in, DATA_SIZE: byte enables.
- in_req_data, in, 8*DATA_SIZE: write data.
- in_req_tag, in, TAG_IN_WIDTH: cache tag.
- in_rsp_valid/in_rsp_ready, out/in, 1: response handshake to the cache.
- in_rsp_data, out, 8*DATA_SIZE: response data.
- in_rsp_tag, out, TAG_IN_WIDTH: restored tag.
- out_req_valid/out_req_ready, out/in, 1: request handshake to memory.
- out_req_rw, out_req_addr, out_req_byteen, out_req_data: out, forwarded unchanged.
- out_req_tag, out, ID_WIDTH: allocated ID. 0 for writes.
- out_rsp_valid/out_rsp_ready, in/out, 1: response handshake from memory.
- out_rsp_data, in, 8*DATA_SIZE: response data.
- out_rsp_tag, in, ID_WIDTH: returned ID.
- pending, out, ID_WIDTH+1: number of IDs currently allocated.
- err, out, 1: sticky protocol-error flag (see Configuration).

## Operation
State:
- free_mask[NUM_IDS]: 1 = ID is free.
- tag_table[NUM_IDS][TAG_IN_WIDTH]: parked original tags.
- One-entry response register: rsp_valid_q, rsp_data_q, rsp_tag_q.
- pending counter and err flag.

Request path (combinational pass-through):
- All request fields are forwarded unchanged.
- out_req_valid = in_req_valid && (in_req_rw || |free_mask).
- in_req_ready = out_req_ready && (in_req_rw || |free_mask).
- When the free list is empty, reads stall and writes still pass.
- A read is assigned alloc_id, the lowest-index free ID (priority encoder).
- On a read fire:
  - free_mask[alloc_id] is cleared.
  - tag_table[alloc_id] is loaded with in_req_tag.
  - out_req_tag = alloc_id.
- Writes allocate nothing, produce no response, and drive out_req_tag = 0.

Response path (registered, one stage):
- out_rsp_ready = !rsp_valid_q || in_rsp_ready.
- On an out_rsp fire:
  - rsp_data_q is loaded with out_rsp_data.
  - rsp_tag_q is loaded with tag_table[out_rsp_tag].
  - rsp_valid_q is set.
  - free_mask[out_rsp_tag] is set, releasing the ID.
- Outputs: in_rsp_valid = rsp_valid_q, in_rsp_data = rsp_data_q, in_rsp_tag = rsp_tag_q.
- An in_rsp fire with no new out_rsp fire clears rsp_valid_q.

Pending counter:
- Increments on a read fire and decrements on a response release.
- Unchanged when both happen in the same cycle.

Boundary conditions:
- Allocation and release in the same cycle:
  - Allocation uses the current free_mask.
  - A just-released ID becomes allocatable next cycle, never in the same cycle.
- Full (pending == NUM_IDS): reads stall. A release in the same cycle lets a stalled read proceed next cycle.
- Responses may return in any order.

## Timing
- Request path: 0-cycle latency. Combinational from in_req_* and out_req_ready.
- Response path: 1-cycle latency from an out_rsp fire to in_rsp_valid.
- Response throughput is 1 per cycle when in_rsp_ready is held high.
- No combinational path from out_rsp_* to in_rsp_*.
- Reset (asynchronous assert, synchronous release via flops):
  - free_mask = all ones.
  - rsp_valid_q = 0, pending = 0, err = 0.
  - tag_table contents are don't-care.
  - Reset asserted mid-operation drops all in-flight IDs and any buffered response.

## Configuration
Macro MEM_TAG_REMAP_CHECK_EN.
- Defined:
  - A response whose out_rsp_tag is currently free is still accepted (out_rsp_ready unchanged).
  - That response is dropped: rsp_valid_q is not set, no release, pending unchanged.
  - err is set and held until reset.
- Undefined:
  - No check is made.
  - Such a response is forwarded with the stale table tag and pending decrements.
  - err is tied to 0.

## Test plan
- Reset, then 3 reads with tags 0x101/0x102/0x103 -> out_req_tag 0/1/2, pending = 3.
- Respond on IDs 2, 0, 1 with data D2/D0/D1 -> in_rsp gives (0x103,D2), (0x101,D0), (0x102,D1), each one cycle after the fire; pending returns to 0.
- NUM_IDS = 8 reads outstanding, a 9th read held valid -> in_req_ready = 0. Then a write with byteen 0xFF..FF is presented while the 9th read is still pending -> the write passes with out_req_tag = 0. Release ID 5 -> next cycle the 9th read gets out_req_tag 5.
- Hold in_rsp_ready = 0 with a response buffered -> out_rsp_ready = 0, and a second memory response is held off. Raise in_rsp_ready -> back-to-back delivery at 1 per cycle.
- With MEM_TAG_REMAP_CHECK_EN, send a response on free ID 4 -> no in_rsp_valid, err = 1 and sticky, pending unchanged.
- Assert reset with 4 reads outstanding and a response buffered -> in_rsp_valid = 0, pending = 0, next read gets ID 0.

Source files
------------

// File: rtl/mem_tag_remap.sv
// mem_tag_remap: swaps wide cache read tags for small memory-side IDs taken from a
// free list, parks the original tag on chip, and restores it when the response returns.
// Optional build macro MEM_TAG_REMAP_CHECK_EN: drop responses whose ID is not allocated
// and raise a sticky err flag.
module mem_tag_remap #(
    parameter int unsigned ADDR_WIDTH   = 26,
    parameter int unsigned DATA_SIZE    = 64,
    parameter int unsigned TAG_IN_WIDTH = 12,
    parameter int unsigned NUM_IDS      = 8,
    localparam int unsigned ID_WIDTH    = $clog2(NUM_IDS)
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      in_req_valid,
    output logic                      in_req_ready,
    input  logic                      in_req_rw,
    input  logic [ADDR_WIDTH-1:0]     in_req_addr,
    input  logic [DATA_SIZE-1:0]      in_req_byteen,
    input  logic [8*DATA_SIZE-1:0]    in_req_data,
    input  logic [TAG_IN_WIDTH-1:0]   in_req_tag,

    output logic                      in_rsp_valid,
    input  logic                      in_rsp_ready,
    output logic [8*DATA_SIZE-1:0]    in_rsp_data,
    output logic [TAG_IN_WIDTH-1:0]   in_rsp_tag,

    output logic                      out_req_valid,
    input  logic                      out_req_ready,
    output logic                      out_req_rw,
    output logic [ADDR_WIDTH-1:0]     out_req_addr,
    output logic [DATA_SIZE-1:0]      out_req_byteen,
    output logic [8*DATA_SIZE-1:0]    out_req_data,
    output logic [ID_WIDTH-1:0]       out_req_tag,

    input  logic                      out_rsp_valid,
    output logic                      out_rsp_ready,
    input  logic [8*DATA_SIZE-1:0]    out_rsp_data,
    input  logic [ID_WIDTH-1:0]       out_rsp_tag,

    output logic [ID_WIDTH:0]         pending,
    output logic                      err
);

    logic [NUM_IDS-1:0]      free_mask_q, free_mask_d;
    logic [TAG_IN_WIDTH-1:0] tag_table_q [NUM_IDS];
    logic [TAG_IN_WIDTH-1:0] tag_table_d [NUM_IDS];
    logic                    rsp_valid_q, rsp_valid_d;
    logic [8*DATA_SIZE-1:0]  rsp_data_q, rsp_data_d;
    logic [TAG_IN_WIDTH-1:0] rsp_tag_q, rsp_tag_d;
    logic [ID_WIDTH:0]       pending_q, pending_d;

    logic [ID_WIDTH-1:0]     alloc_id;
    logic                    has_free;
    logic                    req_ok;
    logic                    rd_fire;
    logic                    rsp_fire;
    logic                    rsp_bad;
    logic                    rsp_accept;

    // Lowest-index free ID; a release this cycle is not visible until next cycle.
    always_comb begin
        alloc_id = '0;
        for (int i = int'(NUM_IDS) - 1; i >= 0; i--) begin
            if (free_mask_q[i]) alloc_id = ID_WIDTH'(i);
        end
    end

    assign has_free = |free_mask_q;
    assign req_ok   = in_req_rw || has_free;

    // Request path: pure pass-through, reads gated on an available ID.
    assign out_req_valid  = in_req_valid && req_ok;
    assign in_req_ready   = out_req_ready && req_ok;
    assign out_req_rw     = in_req_rw;
    assign out_req_addr   = in_req_addr;
    assign out_req_byteen = in_req_byteen;
    assign out_req_data   = in_req_data;
    assign out_req_tag    = in_req_rw ? '0 : alloc_id;

    assign rd_fire  = in_req_valid && in_req_ready && !in_req_rw;

    // Response path: one-entry skid register, accepts when empty or draining.
    assign out_rsp_ready = !rsp_valid_q || in_rsp_ready;
    assign rsp_fire      = out_rsp_valid && out_rsp_ready;

`ifdef MEM_TAG_REMAP_CHECK_EN
    logic err_q, err_d;

    // A response on an ID that is not outstanding is swallowed and flagged.
    assign rsp_bad = rsp_fire && free_mask_q[out_rsp_tag];

    // Sticky error until reset.
    always_comb begin
        err_d = err_q | rsp_bad;
    end

    // Error flag register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err = err_q;
`else
    assign rsp_bad = 1'b0;
    assign err     = 1'b0;
`endif

    assign rsp_accept = rsp_fire && !rsp_bad;

    // Next-state for free list, tag table, response buffer and pending count.
    always_comb begin
        free_mask_d = free_mask_q;
        tag_table_d = tag_table_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_tag_d   = rsp_tag_q;
        pending_d   = pending_q;

        // Release first so a same-cycle allocation of the same slot wins.
        if (rsp_accept) free_mask_d[out_rsp_tag] = 1'b1;
        if (rd_fire) begin
            free_mask_d[alloc_id] = 1'b0;
            tag_table_d[alloc_id] = in_req_tag;
        end

        if (rsp_accept) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = out_rsp_data;
            rsp_tag_d   = tag_table_q[out_rsp_tag];
        end else if (in_rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        unique case ({rd_fire, rsp_accept})
            2'b10:   pending_d = pending_q + (ID_WIDTH+1)'(1);
            2'b01:   pending_d = pending_q - (ID_WIDTH+1)'(1);
            default: pending_d = pending_q;
        endcase
    end

    // Control and response state with asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            free_mask_q <= '1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
            pending_q   <= '0;
        end else begin
            free_mask_q <= free_mask_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_tag_q   <= rsp_tag_d;
            pending_q   <= pending_d;
        end
    end

    // Parked tags; contents are only meaningful for allocated IDs, so no reset.
    always_ff @(posedge clk) begin
        tag_table_q <= tag_table_d;
    end

    assign in_rsp_valid = rsp_valid_q;
    assign in_rsp_data  = rsp_data_q;
    assign in_rsp_tag   = rsp_tag_q;
    assign pending      = pending_q;

endmodule

// File: tb/tb_mem_tag_remap.sv
// Self-checking bench for mem_tag_remap: directed scenarios plus randomized traffic,
// checked against a scoreboard of outstanding IDs and expected deliveries.
module tb_mem_tag_remap;

    localparam int unsigned AW = 26;
    localparam int unsigned DS = 8;
    localparam int unsigned DW = 8 * DS;
    localparam int unsigned TW = 12;
    localparam int unsigned N  = 8;
    localparam int unsigned IW = $clog2(N);

    logic          clk;
    logic          reset;
    logic          in_req_valid, in_req_ready, in_req_rw;
    logic [AW-1:0] in_req_addr;
    logic [DS-1:0] in_req_byteen;
    logic [DW-1:0] in_req_data;
    logic [TW-1:0] in_req_tag;
    logic          in_rsp_valid, in_rsp_ready;
    logic [DW-1:0] in_rsp_data;
    logic [TW-1:0] in_rsp_tag;
    logic          out_req_valid, out_req_ready, out_req_rw;
    logic [AW-1:0] out_req_addr;
    logic [DS-1:0] out_req_byteen;
    logic [DW-1:0] out_req_data;
    logic [IW-1:0] out_req_tag;
    logic          out_rsp_valid, out_rsp_ready;
    logic [DW-1:0] out_rsp_data;
    logic [IW-1:0] out_rsp_tag;
    logic [IW:0]   pending;
    logic          err;

    mem_tag_remap #(
        .ADDR_WIDTH  (AW),
        .DATA_SIZE   (DS),
        .TAG_IN_WIDTH(TW),
        .NUM_IDS     (N)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_req_valid  (in_req_valid),
        .in_req_ready  (in_req_ready),
        .in_req_rw     (in_req_rw),
        .in_req_addr   (in_req_addr),
        .in_req_byteen (in_req_byteen),
        .in_req_data   (in_req_data),
        .in_req_tag    (in_req_tag),
        .in_rsp_valid  (in_rsp_valid),
        .in_rsp_ready  (in_rsp_ready),
        .in_rsp_data   (in_rsp_data),
        .in_rsp_tag    (in_rsp_tag),
        .out_req_valid (out_req_valid),
        .out_req_ready (out_req_ready),
        .out_req_rw    (out_req_rw),
        .out_req_addr  (out_req_addr),
        .out_req_byteen(out_req_byteen),
        .out_req_data  (out_req_data),
        .out_req_tag   (out_req_tag),
        .out_rsp_valid (out_rsp_valid),
        .out_rsp_ready (out_rsp_ready),
        .out_rsp_data  (out_rsp_data),
        .out_rsp_tag   (out_rsp_tag),
        .pending       (pending),
        .err           (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: outstanding ID -> original tag, and deliveries still owed.
    typedef struct {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } rsp_t;

    logic [TW-1:0] tag_of [int];
    rsp_t          exp_rsp [$];
    bit            m_err;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string name, input logic [63:0] got,
                            input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int lowest_free();
        for (int i = 0; i < int'(N); i++) begin
            if (!tag_of.exists(i)) return i;
        end
        return 0;
    endfunction

    // Check every output for the current inputs, advance the model, step one clock.
    task automatic do_cycle();
        bit   ok;
        bit   buffered;
        int   alloc;
        rsp_t r;
        #1;
        ok       = in_req_rw || (tag_of.num() < int'(N));
        alloc    = lowest_free();
        buffered = exp_rsp.size() > 0;
        check_eq("out_req_valid", out_req_valid, in_req_valid && ok);
        check_eq("in_req_ready", in_req_ready, out_req_ready && ok);
        if (in_req_valid && ok) begin
            check_eq("out_req_tag", out_req_tag, in_req_rw ? 0 : alloc);
            check_eq("out_req_rw", out_req_rw, in_req_rw);
            check_eq("out_req_addr", out_req_addr, in_req_addr);
            check_eq("out_req_byteen", out_req_byteen, in_req_byteen);
            check_eq("out_req_data", out_req_data, in_req_data);
        end
        check_eq("in_rsp_valid", in_rsp_valid, buffered);
        if (buffered) begin
            check_eq("in_rsp_tag", in_rsp_tag, exp_rsp[0].tag);
            check_eq("in_rsp_data", in_rsp_data, exp_rsp[0].data);
        end
        check_eq("out_rsp_ready", out_rsp_ready, !buffered || in_rsp_ready);
        check_eq("pending", pending, tag_of.num());
        check_eq("err", err, m_err);

        if (buffered && in_rsp_ready) void'(exp_rsp.pop_front());
        if (out_rsp_valid && (!buffered || in_rsp_ready)) begin
            if (tag_of.exists(int'(out_rsp_tag))) begin
                r.tag  = tag_of[int'(out_rsp_tag)];
                r.data = out_rsp_data;
                exp_rsp.push_back(r);
                tag_of.delete(int'(out_rsp_tag));
            end else begin
                // Only the checked build is ever sent a response on a free ID.
                m_err = 1'b1;
            end
        end
        if (in_req_valid && out_req_ready && ok && !in_req_rw) tag_of[alloc] = in_req_tag;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        in_req_valid  = 1'b0;
        in_req_rw     = 1'b0;
        out_rsp_valid = 1'b0;
        out_req_ready = 1'b1;
        in_rsp_ready  = 1'b1;
    endtask

    task automatic set_req(input logic rw, input logic [TW-1:0] tag);
        in_req_valid  = 1'b1;
        in_req_rw     = rw;
        in_req_tag    = tag;
        in_req_addr   = AW'($urandom);
        in_req_byteen = DS'($urandom);
        in_req_data   = {$urandom, $urandom};
    endtask

    task automatic read_chk(input logic [TW-1:0] tag, input int exp_id);
        set_req(1'b0, tag);
        #1;
        check_eq("read_id", out_req_tag, exp_id);
        do_cycle();
        in_req_valid = 1'b0;
    endtask

    task automatic resp(input int id, input logic [DW-1:0] data);
        out_rsp_valid = 1'b1;
        out_rsp_tag   = IW'(id);
        out_rsp_data  = data;
        do_cycle();
        out_rsp_valid = 1'b0;
    endtask

    // Asynchronous assert away from the clock edge; release one cycle later.
    task automatic do_reset();
        idle();
        reset = 1'b0;
        #1;
        check_eq("rst_in_rsp_valid", in_rsp_valid, 0);
        check_eq("rst_pending", pending, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_out_rsp_ready", out_rsp_ready, 1);
        tag_of.delete();
        exp_rsp.delete();
        m_err = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int ids[$];
        reset        = 1'b1;
        in_req_addr  = '0;
        in_req_byteen = '0;
        in_req_data  = '0;
        in_req_tag   = '0;
        out_rsp_tag  = '0;
        out_rsp_data = '0;
        m_err        = 1'b0;
        idle();
        @(negedge clk);
        do_reset();
        do_cycle();

        // Three reads get IDs 0,1,2; out-of-order responses restore tags.
        read_chk(12'h101, 0);
        read_chk(12'h102, 1);
        read_chk(12'h103, 2);
        #1 check_eq("pending_3", pending, 3);
        resp(2, 64'hD2D2_D2D2_0000_0002);
        #1 check_eq("rsp_a_tag", in_rsp_tag, 12'h103);
        resp(0, 64'hD0D0_D0D0_0000_0000);
        #1 check_eq("rsp_b_tag", in_rsp_tag, 12'h101);
        resp(1, 64'hD1D1_D1D1_0000_0001);
        #1 check_eq("rsp_c_tag", in_rsp_tag, 12'h102);
        check_eq("rsp_c_data", in_rsp_data, 64'hD1D1_D1D1_0000_0001);
        check_eq("pending_0", pending, 0);
        do_cycle();

        // Fill all IDs, stall a 9th read, let a write through, then release ID 5.
        for (int i = 0; i < int'(N); i++) read_chk(TW'(12'h200 + i), i);
        set_req(1'b0, 12'h2AA);
        #1 check_eq("full_stall", in_req_ready, 0);
        do_cycle();
        set_req(1'b1, 12'h3FF);
        in_req_byteen = '1;
        #1 check_eq("full_write_rdy", in_req_ready, 1);
        check_eq("full_write_tag", out_req_tag, 0);
        do_cycle();
        set_req(1'b0, 12'h2AA);
        out_rsp_valid = 1'b1;
        out_rsp_tag   = IW'(5);
        out_rsp_data  = 64'h5555_0000_5555_0000;
        #1 check_eq("release_same_cycle", in_req_ready, 0);
        do_cycle();
        out_rsp_valid = 1'b0;
        #1 check_eq("after_release_rdy", in_req_ready, 1);
        check_eq("after_release_id", out_req_tag, 5);
        do_cycle();
        in_req_valid = 1'b0;
        for (int i = 0; i < int'(N); i++) resp(i, {$urandom, $urandom});
        do_cycle();

        // Backpressure from the cache holds off memory responses.
        read_chk(12'h011, 0);
        read_chk(12'h022, 1);
        read_chk(12'h033, 2);
        in_rsp_ready = 1'b0;
        resp(0, 64'hAAAA_0000_0000_0000);
        out_rsp_valid = 1'b1;
        out_rsp_tag   = IW'(1);
        out_rsp_data  = 64'hBBBB_0000_0000_0001;
        #1 check_eq("held_off", out_rsp_ready, 0);
        do_cycle();
        do_cycle();
        in_rsp_ready = 1'b1;
        do_cycle();
        resp(2, 64'hCCCC_0000_0000_0002);
        #1 check_eq("b2b_tag", in_rsp_tag, 12'h033);
        do_cycle();
        do_cycle();

`ifdef MEM_TAG_REMAP_CHECK_EN
        // Response on a free ID is swallowed and flags a sticky error.
        resp(4, 64'h4444_4444_4444_4444);
        #1 check_eq("bad_no_rsp", in_rsp_valid, 0);
        check_eq("bad_err", err, 1);
        check_eq("bad_pending", pending, 0);
        do_cycle();
        do_cycle();
        #1 check_eq("bad_err_sticky", err, 1);
`endif

        // Reset with reads outstanding and a response buffered.
        for (int i = 0; i < 4; i++) read_chk(TW'(12'h400 + i), i);
        in_rsp_ready = 1'b0;
        resp(1, 64'h1111_2222_3333_4444);
        #1 check_eq("pre_reset_buf", in_rsp_valid, 1);
        do_reset();
        read_chk(12'h4AA, 0);
        do_cycle();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(1, 0) == 1) set_req($urandom_range(3, 0) == 0, TW'($urandom));
            else in_req_valid = 1'b0;
            out_req_ready = $urandom_range(3, 0) != 0;
            in_rsp_ready  = $urandom_range(2, 0) != 0;
            ids.delete();
            foreach (tag_of[k]) ids.push_back(k);
            out_rsp_valid = 1'b0;
            if (ids.size() > 0 && $urandom_range(1, 0) == 1) begin
                out_rsp_valid = 1'b1;
                out_rsp_tag   = IW'(ids[$urandom_range(ids.size() - 1, 0)]);
                out_rsp_data  = {$urandom, $urandom};
            end
            do_cycle();
        end
        idle();
        do_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
